// File: rtl/collision_manager_pkg.sv
// ---------------------------------------------------------------------------
// collision_manager_pkg
//   Shared definitions for the collision arbiter slice:
//     - state_t    : FSM state encoding (3 bits)
//     - track geometry constants (screen pixels)
//     - ext11()    : zero-extends a 10-bit coordinate to 11 bits, so that
//                    coordinate + sprite size never wraps in a compare
// ---------------------------------------------------------------------------
package collision_manager_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_RIVAL_HIT = 3'd1,
        ST_WALL_HIT  = 3'd2,
        ST_GRACE     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int OFFSET_BG_X = 200;  // track x origin on screen
    localparam int BG_LEFT     = 44;   // left track edge, relative to OFFSET_BG_X
    localparam int BG_RIGHT    = 104;  // right rival spawn limit, relative to OFFSET_BG_X
    localparam int CAR_WIDTH   = 14;   // rival sprite width
    localparam int CAR_HEIGHT  = 16;   // rival sprite height

    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/collision_manager_if.sv
// ---------------------------------------------------------------------------
// collision_manager_if
//   Bundles the per-frame strobe, the sprite positions and the arbiter
//   results exchanged between the game logic and collision_manager.
//     frame_end          1-cycle pulse at end of each VGA frame
//     player_x/_y        player top-left position (10 bits each)
//     rival_x/_y         rival top-left position (10 bits each)
//     collide_with_rival 1 = rival frozen
//     SCROLL_SPEED_Y     1 = scrolling enabled
//     lives              remaining lives (2 bits)
//     blink              player sprite blank request
//     game_over          sticky end-of-game flag
//   master : game side (drives frame strobe and positions)
//   slave  : collision_manager (drives results)
// ---------------------------------------------------------------------------
interface collision_manager_if;

    logic       frame_end;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] rival_x;
    logic [9:0] rival_y;
    logic       collide_with_rival;
    logic       SCROLL_SPEED_Y;
    logic [1:0] lives;
    logic       blink;
    logic       game_over;

    modport master (
        output frame_end, player_x, player_y, rival_x, rival_y,
        input  collide_with_rival, SCROLL_SPEED_Y, lives, blink, game_over
    );

    modport slave (
        input  frame_end, player_x, player_y, rival_x, rival_y,
        output collide_with_rival, SCROLL_SPEED_Y, lives, blink, game_over
    );

endinterface

// File: rtl/collision_manager_rect_overlap.sv
// ---------------------------------------------------------------------------
// rect_overlap
//   Combinational axis-aligned bounding-box overlap test between rectangle A
//   (size A_W x A_H) and rectangle B (size B_W x B_H), given their top-left
//   corners. Strict compares: rectangles that merely touch do not overlap.
//   All sums are formed in 11 bits so they cannot wrap.
//   Ports:
//     a_x, a_y  in  10  top-left of A
//     b_x, b_y  in  10  top-left of B
//     hit       out 1   1 = interiors overlap
// ---------------------------------------------------------------------------
module rect_overlap
    import collision_manager_pkg::*;
#(
    parameter int A_W = 14,
    parameter int A_H = 16,
    parameter int B_W = 14,
    parameter int B_H = 16
) (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic       hit
);

    logic x_hit;
    logic y_hit;

    assign x_hit = (ext11(a_x) < ext11(b_x) + 11'(B_W)) &&
                   (ext11(b_x) < ext11(a_x) + 11'(A_W));
    assign y_hit = (ext11(a_y) < ext11(b_y) + 11'(B_H)) &&
                   (ext11(b_y) < ext11(a_y) + 11'(A_H));
    assign hit   = x_hit && y_hit;

endmodule

// File: rtl/collision_manager.sv
// ---------------------------------------------------------------------------
// collision_manager
//   Per-frame collision arbiter. On each frame_end it samples the player and
//   rival positions, detects player/rival overlap and player/track-boundary
//   excursions, and steps the RUN / RIVAL_HIT / WALL_HIT / GRACE / GAME_OVER
//   state machine. All outputs are registered and change only in the cycle
//   after a frame_end sample.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous, active-low reset
//     bus      slave side of collision_manager_if (positions in, results out)
// ---------------------------------------------------------------------------
module collision_manager
    import collision_manager_pkg::*;
#(
    parameter int PLAYER_WIDTH  = 14,
    parameter int PLAYER_HEIGHT = 16,
    parameter int HIT_FRAMES    = 60,
    parameter int WALL_FRAMES   = 30,
    parameter int GRACE_FRAMES  = 90,
    parameter int LIVES         = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    collision_manager_if.slave  bus
);

    localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  WALL_LAST  = 8'(WALL_FRAMES - 1);
    localparam logic [7:0]  GRACE_LAST = 8'(GRACE_FRAMES - 1);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [10:0] X_MIN      = 11'(OFFSET_BG_X + BG_LEFT);
    localparam logic [10:0] X_MAX      = 11'(OFFSET_BG_X + BG_RIGHT + CAR_WIDTH);

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [1:0] lives_q, lives_d;
    logic       collide_q, collide_d;
    logic       scroll_q, scroll_d;
    logic       blink_q, blink_d;
    logic       game_over_q, game_over_d;

    logic       ovl;
    logic       oob;

    rect_overlap #(
        .A_W (PLAYER_WIDTH),
        .A_H (PLAYER_HEIGHT),
        .B_W (CAR_WIDTH),
        .B_H (CAR_HEIGHT)
    ) u_ovl (
        .a_x (bus.player_x),
        .a_y (bus.player_y),
        .b_x (bus.rival_x),
        .b_y (bus.rival_y),
        .hit (ovl)
    );

    assign oob = (ext11(bus.player_x) < X_MIN) ||
                 (ext11(bus.player_x) + 11'(PLAYER_WIDTH) > X_MAX);

    // Next-state logic. Every transition into a new state clears the frame
    // timer; the timer only advances while a timed state is held.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        lives_d = lives_q;

        if (bus.frame_end) begin
            case (state_q)
                ST_RUN: begin
                    // A rival hit takes priority over a simultaneous wall hit.
                    if (ovl) begin
                        state_d = ST_RIVAL_HIT;
                        tmr_d   = 8'd0;
                        lives_d = lives_q - 2'd1;
                    end else if (oob) begin
                        state_d = ST_WALL_HIT;
                        tmr_d   = 8'd0;
                    end
                end
                ST_RIVAL_HIT: begin
                    if (tmr_q == HIT_LAST) begin
                        state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_GRACE;
                        tmr_d   = 8'd0;
                    end else begin
                        tmr_d = tmr_q + 8'd1;
                    end
                end
                ST_WALL_HIT: begin
                    // The stall lasts at least WALL_FRAMES and then until the
                    // player is back on the track.
                    if (tmr_q >= WALL_LAST && !oob) begin
                        state_d = ST_RUN;
                        tmr_d   = 8'd0;
                    end else if (tmr_q != 8'hFF) begin
                        tmr_d = tmr_q + 8'd1;
                    end
                end
                ST_GRACE: begin
                    if (oob) begin
                        state_d = ST_WALL_HIT;
                        tmr_d   = 8'd0;
                    end else if (tmr_q == GRACE_LAST) begin
                        state_d = ST_RUN;
                        tmr_d   = 8'd0;
                    end else begin
                        tmr_d = tmr_q + 8'd1;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_RUN;
                    tmr_d   = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs describe
    // the state the machine is entering.
    always_comb begin
        collide_d   = (state_d == ST_RIVAL_HIT) || (state_d == ST_GAME_OVER);
        scroll_d    = (state_d == ST_RUN) || (state_d == ST_GRACE);
        blink_d     = (state_d == ST_GRACE) && tmr_d[2];
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            tmr_q       <= 8'd0;
            lives_q     <= LIVES_INIT;
            collide_q   <= 1'b0;
            scroll_q    <= 1'b1;
            blink_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lives_q     <= lives_d;
            collide_q   <= collide_d;
            scroll_q    <= scroll_d;
            blink_q     <= blink_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.collide_with_rival = collide_q;
    assign bus.SCROLL_SPEED_Y     = scroll_q;
    assign bus.lives              = lives_q;
    assign bus.blink              = blink_q;
    assign bus.game_over          = game_over_q;

endmodule

// File: tb/tb_collision_manager.sv
// ---------------------------------------------------------------------------
// tb_collision_manager
//   Directed stimulus for collision_manager. Each stimulus step queues the
//   hand-computed output vector {collide, scroll, lives, blink, game_over};
//   a separate monitor pops and compares one cycle after each frame_end
//   (or after an explicit check request).
// ---------------------------------------------------------------------------
module tb_collision_manager;

    logic clk;
    logic reset_n;
    logic chk_now;

    collision_manager_if bus ();

    collision_manager dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [5:0] v;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: compare outputs 1 time unit after the edge that sampled a
    // frame_end (or a check request).
    always begin
        @(posedge clk);
        if (bus.frame_end || chk_now) begin
            logic [5:0] got;
            exp_t       e;
            #1;
            got = {bus.collide_with_rival, bus.SCROLL_SPEED_Y, bus.lives,
                   bus.blink, bus.game_over};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expect got=%b", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s got {col,scr,lives,blk,go}=%b required=%b",
                             e.nm, got, e.v);
                end
            end
        end
    end

    function automatic logic [5:0] pack(input logic c, input logic s,
                                        input logic [1:0] l, input logic b,
                                        input logic g);
        return {c, s, l, b, g};
    endfunction

    task automatic frame(input logic [9:0] px, input logic [9:0] py,
                         input logic [9:0] rx, input logic [9:0] ry,
                         input logic [5:0] ev, input string nm);
        exp_t e;
        @(negedge clk);
        bus.player_x  = px;
        bus.player_y  = py;
        bus.rival_x   = rx;
        bus.rival_y   = ry;
        bus.frame_end = 1'b1;
        e.v = ev;
        e.nm = nm;
        exp_q.push_back(e);
        @(negedge clk);
        bus.frame_end = 1'b0;
        // Positions move between frames without any effect.
        bus.player_x  = 10'd0;
        bus.rival_x   = 10'd0;
    endtask

    task automatic check_now(input logic [5:0] ev, input string nm);
        exp_t e;
        e.v = ev;
        e.nm = nm;
        exp_q.push_back(e);
        chk_now = 1'b1;
        @(negedge clk);
        chk_now = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Safe positions: player on track, rival far away vertically.
    localparam logic [9:0] SPX = 10'd260, SPY = 10'd300;
    localparam logic [9:0] FRX = 10'd260, FRY = 10'd100;

    initial begin
        logic [5:0] rst_v;
        rst_v         = pack(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        reset_n       = 1'b1;
        chk_now       = 1'b0;
        bus.frame_end = 1'b0;
        bus.player_x  = SPX;
        bus.player_y  = SPY;
        bus.rival_x   = FRX;
        bus.rival_y   = FRY;

        // 1. reset values
        do_reset();
        @(negedge clk);
        check_now(rst_v, "reset");

        // 2. rival hit, freeze 60 frames, then grace with blink, ovl ignored
        frame(10'd250, 10'd300, 10'd255, 10'd290,
              pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "hit_enter");
        for (int i = 1; i <= 60; i++) begin
            if (i < 60)
                frame(SPX, SPY, FRX, FRY, pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "hit_hold");
            else
                frame(SPX, SPY, FRX, FRY, pack(1'b0, 1'b1, 2'd2, 1'b0, 1'b0), "grace_enter");
        end
        for (int j = 1; j <= 90; j++) begin
            logic b;
            b = ((j >> 2) & 1) != 0;
            if (j < 90)
                frame(10'd250, 10'd300, 10'd255, 10'd290,
                      pack(1'b0, 1'b1, 2'd2, b, 1'b0), "grace_blink");
            else
                frame(10'd250, 10'd300, 10'd255, 10'd290,
                      pack(1'b0, 1'b1, 2'd2, 1'b0, 1'b0), "grace_exit");
        end
        frame(SPX, SPY, FRX, FRY, pack(1'b0, 1'b1, 2'd2, 1'b0, 1'b0), "run_after_grace");

        // 3. wall hit: left excursion, minimum stall, then right-edge limits
        do_reset();
        @(negedge clk);
        check_now(rst_v, "reset_t3");
        frame(10'd240, SPY, FRX, FRY, pack(1'b0, 1'b0, 2'd3, 1'b0, 1'b0), "wall_enter");
        for (int k = 1; k <= 30; k++) begin
            if (k == 5)
                frame(10'd240, 10'd300, 10'd245, 10'd300,
                      pack(1'b0, 1'b0, 2'd3, 1'b0, 1'b0), "wall_ovl_ignored");
            else if (k < 10)
                frame(10'd240, SPY, FRX, FRY, pack(1'b0, 1'b0, 2'd3, 1'b0, 1'b0), "wall_oob");
            else if (k < 30)
                frame(SPX, SPY, FRX, FRY, pack(1'b0, 1'b0, 2'd3, 1'b0, 1'b0), "wall_min");
            else
                frame(SPX, SPY, FRX, FRY, pack(1'b0, 1'b1, 2'd3, 1'b0, 1'b0), "wall_exit");
        end
        frame(10'd304, SPY, FRX, FRY, pack(1'b0, 1'b1, 2'd3, 1'b0, 1'b0), "right_inside");
        frame(10'd305, SPY, FRX, FRY, pack(1'b0, 1'b0, 2'd3, 1'b0, 1'b0), "right_oob");

        // 4. ovl beats oob; touching edges are not a hit
        do_reset();
        frame(10'd243, 10'd300, 10'd245, 10'd300,
              pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "ovl_beats_oob");
        do_reset();
        frame(10'd264, 10'd300, 10'd250, 10'd300,
              pack(1'b0, 1'b1, 2'd3, 1'b0, 1'b0), "edge_touch_x");
        frame(10'd250, 10'd316, 10'd250, 10'd300,
              pack(1'b0, 1'b1, 2'd3, 1'b0, 1'b0), "edge_touch_y");
        frame(10'd263, 10'd300, 10'd250, 10'd300,
              pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "one_px_in");

        // 5. three hits down to game over, which is terminal
        do_reset();
        for (int h = 1; h <= 3; h++) begin
            logic [1:0] l;
            l = 2'(3 - h);
            frame(10'd250, 10'd300, 10'd255, 10'd290,
                  pack(1'b1, 1'b0, l, 1'b0, 1'b0), "multi_hit");
            for (int i = 1; i <= 60; i++) begin
                if (i < 60)
                    frame(SPX, SPY, FRX, FRY, pack(1'b1, 1'b0, l, 1'b0, 1'b0), "multi_hold");
                else if (h < 3)
                    frame(SPX, SPY, FRX, FRY, pack(1'b0, 1'b1, l, 1'b0, 1'b0), "multi_grace");
                else
                    frame(SPX, SPY, FRX, FRY, pack(1'b1, 1'b0, 2'd0, 1'b0, 1'b1), "game_over");
            end
            if (h < 3) begin
                for (int j = 1; j <= 90; j++) begin
                    logic b;
                    b = ((j >> 2) & 1) != 0;
                    frame(SPX, SPY, FRX, FRY,
                          pack(1'b0, 1'b1, l, (j < 90) ? b : 1'b0, 1'b0), "multi_grace_run");
                end
            end
        end
        for (int i = 0; i < 4; i++)
            frame(10'd250, 10'd300, 10'd255, 10'd290,
                  pack(1'b1, 1'b0, 2'd0, 1'b0, 1'b1), "go_sticky");
        frame(10'd240, SPY, FRX, FRY, pack(1'b1, 1'b0, 2'd0, 1'b0, 1'b1), "go_sticky_oob");

        // 6. asynchronous reset in the middle of RIVAL_HIT
        do_reset();
        frame(10'd250, 10'd300, 10'd255, 10'd290,
              pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "pre_abort_hit");
        for (int i = 1; i <= 20; i++)
            frame(SPX, SPY, FRX, FRY, pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "pre_abort_hold");
        @(negedge clk);
        reset_n = 1'b0;
        check_now(rst_v, "mid_reset");
        reset_n = 1'b1;
        frame(10'd250, 10'd300, 10'd255, 10'd290,
              pack(1'b1, 1'b0, 2'd2, 1'b0, 1'b0), "hit_after_reset");

        // Drain scoreboard with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() != 0; w++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
